// File: rtl/sram_arb_pkg.sv
// Shared widths, FSM states and command payload for the DE2 async-SRAM arbiter.
package sram_arb_pkg;
    localparam int unsigned SRAM_AW = 18;
    localparam int unsigned SRAM_DW = 16;
    localparam int unsigned SRAM_BW = 2;
    localparam int unsigned CNT_W   = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    typedef struct packed {
        logic               we;
        logic [SRAM_AW-1:0] addr;
        logic [SRAM_DW-1:0] wdata;
        logic [SRAM_BW-1:0] be;
    } cmd_t;
endpackage

// File: rtl/sram_arbiter_rr_arb2.sv
// Two-request round-robin picker; the last-granted pointer moves on a done strobe.
module rr_arb2 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_req,
    input  logic       i_done,
    input  logic       i_done_port,
    output logic       o_valid_c,
    output logic       o_port_c
);
    logic r_last;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_last <= 1'b1;
        end else if (i_done) begin
            r_last <= i_done_port;
        end
    end

    // On a tie the port not granted last wins
    always_comb begin
        o_valid_c = |i_req;
        o_port_c  = i_req[1];
        if (&i_req) begin
            o_port_c = ~r_last;
        end
    end
endmodule

// File: rtl/sram_arbiter.sv
// Two-port round-robin arbiter and counted-strobe access sequencer for a 256Kx16 async SRAM.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int unsigned ACCESS_CYCLES = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_req0,
    input  logic               i_req1,
    input  logic               i_we0,
    input  logic               i_we1,
    input  logic [SRAM_AW-1:0] i_addr0,
    input  logic [SRAM_AW-1:0] i_addr1,
    input  logic [SRAM_DW-1:0] i_wdata0,
    input  logic [SRAM_DW-1:0] i_wdata1,
    input  logic [SRAM_BW-1:0] i_be0,
    input  logic [SRAM_BW-1:0] i_be1,
    output logic               o_ack0,
    output logic               o_ack1,
    output logic [SRAM_DW-1:0] o_rdata0,
    output logic [SRAM_DW-1:0] o_rdata1,
    inout  wire  [SRAM_DW-1:0] io_sram_data,
    output logic [SRAM_AW-1:0] o_sram_address,
    output logic               o_sram_write_enable,
    output logic               o_sram_output_enable,
    output logic               o_cs,
    output logic               o_hb_mask,
    output logic               o_lb_mask
);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    state_t             r_state, w_state_nxt;
    cmd_t               r_cmd, w_cmd_nxt, w_cmd0, w_cmd1;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic               r_port, w_port_nxt;
    logic [SRAM_AW-1:0] r_addr, w_addr_nxt;
    logic               r_cs_n, r_we_n, r_oe_n, r_hb_n, r_lb_n, r_drive;
    logic               w_cs_n_nxt, w_we_n_nxt, w_oe_n_nxt, w_hb_n_nxt, w_lb_n_nxt, w_drive_nxt;
    logic               r_ack0, r_ack1, w_ack0_nxt, w_ack1_nxt;
    logic [SRAM_DW-1:0] r_rdata0, r_rdata1, w_rdata0_nxt, w_rdata1_nxt;
    logic               w_strobe, w_done, w_grant_valid, w_grant_port;

    assign w_cmd0 = '{we: i_we0, addr: i_addr0, wdata: i_wdata0, be: i_be0};
    assign w_cmd1 = '{we: i_we1, addr: i_addr1, wdata: i_wdata1, be: i_be1};
    assign w_done = (r_state == DONE);

    rr_arb2 u_rr (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_req       ({i_req1, i_req0}),
        .i_done      (w_done),
        .i_done_port (r_port),
        .o_valid_c   (w_grant_valid),
        .o_port_c    (w_grant_port)
    );

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state  <= IDLE;
            r_cmd    <= '0;
            r_cnt    <= '0;
            r_port   <= 1'b0;
            r_addr   <= '0;
            r_cs_n   <= 1'b1;
            r_we_n   <= 1'b1;
            r_oe_n   <= 1'b1;
            r_hb_n   <= 1'b1;
            r_lb_n   <= 1'b1;
            r_drive  <= 1'b0;
            r_ack0   <= 1'b0;
            r_ack1   <= 1'b0;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cmd    <= w_cmd_nxt;
            r_cnt    <= w_cnt_nxt;
            r_port   <= w_port_nxt;
            r_addr   <= w_addr_nxt;
            r_cs_n   <= w_cs_n_nxt;
            r_we_n   <= w_we_n_nxt;
            r_oe_n   <= w_oe_n_nxt;
            r_hb_n   <= w_hb_n_nxt;
            r_lb_n   <= w_lb_n_nxt;
            r_drive  <= w_drive_nxt;
            r_ack0   <= w_ack0_nxt;
            r_ack1   <= w_ack1_nxt;
            r_rdata0 <= w_rdata0_nxt;
            r_rdata1 <= w_rdata1_nxt;
        end
    end

    // Next state plus next pin values, so every pin comes straight from a flop
    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_nxt    = r_cmd;
        w_cnt_nxt    = r_cnt;
        w_port_nxt   = r_port;
        w_addr_nxt   = r_addr;
        w_rdata0_nxt = r_rdata0;
        w_rdata1_nxt = r_rdata1;
        w_ack0_nxt   = 1'b0;
        w_ack1_nxt   = 1'b0;
        w_strobe     = 1'b0;

        unique case (r_state)
            IDLE: begin
                if (w_grant_valid) begin
                    w_port_nxt  = w_grant_port;
                    w_cmd_nxt   = w_grant_port ? w_cmd1 : w_cmd0;
                    w_cnt_nxt   = CNT_LOAD;
                    w_state_nxt = ACCESS;
                    w_strobe    = 1'b1;
                end
            end
            ACCESS: begin
                if (r_cnt == '0) begin
                    if (!r_cmd.we) begin
                        if (r_port) w_rdata1_nxt = io_sram_data;
                        else        w_rdata0_nxt = io_sram_data;
                    end
                    w_ack0_nxt  = ~r_port;
                    w_ack1_nxt  = r_port;
                    w_state_nxt = DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                    w_strobe  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        w_cs_n_nxt = ~w_strobe;
        w_we_n_nxt = ~(w_strobe & w_cmd_nxt.we);
        w_oe_n_nxt = ~(w_strobe & ~w_cmd_nxt.we);
        w_hb_n_nxt = ~(w_strobe & w_cmd_nxt.be[1]);
        w_lb_n_nxt = ~(w_strobe & w_cmd_nxt.be[0]);
        if (w_strobe) begin
            w_addr_nxt = w_cmd_nxt.addr;
        end
        // Write data stays on the bus through DONE for hold time
        w_drive_nxt = (w_strobe | (r_state == ACCESS)) & w_cmd_nxt.we;
    end

    assign io_sram_data         = r_drive ? r_cmd.wdata : {SRAM_DW{1'bz}};
    assign o_sram_address       = r_addr;
    assign o_sram_write_enable  = r_we_n;
    assign o_sram_output_enable = r_oe_n;
    assign o_cs                 = r_cs_n;
    assign o_hb_mask            = r_hb_n;
    assign o_lb_mask            = r_lb_n;
    assign o_ack0               = r_ack0;
    assign o_ack1               = r_ack1;
    assign o_rdata0             = r_rdata0;
    assign o_rdata1             = r_rdata1;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: three builds (2, 1, 15 access cycles), each on its own async-SRAM model.
module tb_sram_arbiter;
    localparam int unsigned NI = 3;
    localparam int unsigned AC_TAB [NI] = '{2, 1, 15};

    typedef struct {
        int          inst;
        bit          port;
        bit          we;
        logic [17:0] addr;
        logic [15:0] wdata;
        logic [1:0]  be;
        int          lat;
        int          strobes;
        logic [15:0] rd;
    } vec_t;

    logic clk = 1'b0;
    always #10 clk = ~clk;

    logic [NI-1:0]       rst_v, req0_v, req1_v, we0_v, we1_v;
    logic [NI-1:0][17:0] addr0_v, addr1_v;
    logic [NI-1:0][15:0] wdata0_v, wdata1_v;
    logic [NI-1:0][1:0]  be0_v, be1_v;
    wire  [NI-1:0]       ack0_v, ack1_v, swe_v, soe_v, cs_v, hb_v, lb_v;
    wire  [NI-1:0][15:0] rdata0_v, rdata1_v, bus_v;
    wire  [NI-1:0][17:0] saddr_v;

    int total = 0;
    int bad   = 0;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        wire  [15:0] w_bus;
        logic [15:0] mem [0:262143];
        logic        m_drv  = 1'b0;
        logic [15:0] m_dout = 16'h0000;

        assign w_bus    = m_drv ? m_dout : 16'hzzzz;
        assign bus_v[g] = w_bus;

        sram_arbiter #(.ACCESS_CYCLES(AC_TAB[g])) u_dut (
            .i_clk                (clk),
            .i_rst                (rst_v[g]),
            .i_req0               (req0_v[g]),
            .i_req1               (req1_v[g]),
            .i_we0                (we0_v[g]),
            .i_we1                (we1_v[g]),
            .i_addr0              (addr0_v[g]),
            .i_addr1              (addr1_v[g]),
            .i_wdata0             (wdata0_v[g]),
            .i_wdata1             (wdata1_v[g]),
            .i_be0                (be0_v[g]),
            .i_be1                (be1_v[g]),
            .o_ack0               (ack0_v[g]),
            .o_ack1               (ack1_v[g]),
            .o_rdata0             (rdata0_v[g]),
            .o_rdata1             (rdata1_v[g]),
            .io_sram_data         (w_bus),
            .o_sram_address       (saddr_v[g]),
            .o_sram_write_enable  (swe_v[g]),
            .o_sram_output_enable (soe_v[g]),
            .o_cs                 (cs_v[g]),
            .o_hb_mask            (hb_v[g]),
            .o_lb_mask            (lb_v[g])
        );

        // Async read: outputs drop on any change, valid again 10 ns (tAA) later
        always @(saddr_v[g] or soe_v[g] or cs_v[g] or hb_v[g] or lb_v[g]) begin
            m_drv = 1'b0;
            #10;
            m_dout = {hb_v[g] ? 8'h00 : mem[saddr_v[g]][15:8],
                      lb_v[g] ? 8'h00 : mem[saddr_v[g]][7:0]};
            m_drv  = ~cs_v[g] & ~soe_v[g];
        end

        always @(negedge clk) begin
            if (!cs_v[g] && !swe_v[g]) begin
                if (!hb_v[g]) mem[saddr_v[g]][15:8] <= w_bus[15:8];
                if (!lb_v[g]) mem[saddr_v[g]][7:0]  <= w_bus[7:0];
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic run_vec(input vec_t v, output int lat, output int we_lo, output int oe_lo,
                           output bit clash, output bit hold);
        int i;
        i = v.inst;
        if (v.port) begin
            we1_v[i] = v.we; addr1_v[i] = v.addr; wdata1_v[i] = v.wdata; be1_v[i] = v.be; req1_v[i] = 1'b1;
        end else begin
            we0_v[i] = v.we; addr0_v[i] = v.addr; wdata0_v[i] = v.wdata; be0_v[i] = v.be; req0_v[i] = 1'b1;
        end
        lat = 0; we_lo = 0; oe_lo = 0; clash = 1'b0; hold = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (!swe_v[i]) we_lo++;
            if (!soe_v[i]) begin
                oe_lo++;
                if (bus_v[i] == v.wdata) clash = 1'b1;
            end
            if (v.port ? ack1_v[i] : ack0_v[i]) begin
                lat  = c;
                hold = (bus_v[i] == v.wdata);
                break;
            end
        end
        req0_v[i] = 1'b0;
        req1_v[i] = 1'b0;
        @(posedge clk); #1;
    endtask

    vec_t        vecs [12];
    logic [15:0] exp_rd [NI][2];
    int          ack_c [8];
    int          ack_p [8];
    int          n_ack, a0, a1, lat, we_lo, oe_lo;
    bit          clash, hold;

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // inst, port, we, addr, wdata, be, latency, strobe cycles, expected read data
        vecs[0]  = '{0, 1'b0, 1'b1, 18'h00005, 16'hBEEF, 2'b11, 3, 2, 16'h0000};
        vecs[1]  = '{0, 1'b0, 1'b0, 18'h00005, 16'hDEAD, 2'b11, 3, 2, 16'hBEEF};
        vecs[2]  = '{0, 1'b1, 1'b1, 18'h00009, 16'hFFFF, 2'b11, 3, 2, 16'h0000};
        vecs[3]  = '{0, 1'b1, 1'b1, 18'h00009, 16'h1234, 2'b10, 3, 2, 16'h0000};
        vecs[4]  = '{0, 1'b1, 1'b0, 18'h00009, 16'hDEAD, 2'b11, 3, 2, 16'h12FF};
        vecs[5]  = '{0, 1'b0, 1'b1, 18'h00005, 16'h0000, 2'b00, 3, 2, 16'h0000};
        vecs[6]  = '{0, 1'b0, 1'b0, 18'h00005, 16'hDEAD, 2'b11, 3, 2, 16'hBEEF};
        vecs[7]  = '{0, 1'b1, 1'b0, 18'h00005, 16'hDEAD, 2'b11, 3, 2, 16'hBEEF};
        vecs[8]  = '{1, 1'b0, 1'b1, 18'h3FFFF, 16'hA5A5, 2'b11, 2, 1, 16'h0000};
        vecs[9]  = '{1, 1'b0, 1'b0, 18'h3FFFF, 16'hDEAD, 2'b11, 2, 1, 16'hA5A5};
        vecs[10] = '{2, 1'b0, 1'b1, 18'h3FFFF, 16'hA5A5, 2'b11, 16, 15, 16'h0000};
        vecs[11] = '{2, 1'b0, 1'b0, 18'h3FFFF, 16'hDEAD, 2'b11, 16, 15, 16'hA5A5};
        for (int k = 0; k < int'(NI); k++) begin
            exp_rd[k][0] = 16'h0000;
            exp_rd[k][1] = 16'h0000;
        end

        rst_v = '1; req0_v = '0; req1_v = '0; we0_v = '0; we1_v = '0;
        addr0_v = '0; addr1_v = '0; wdata0_v = '0; wdata1_v = '0; be0_v = '0; be1_v = '0;
        repeat (3) @(posedge clk);
        #1 rst_v = '0;
        @(posedge clk); #1;
        check("rst_ctl", 32'({cs_v[0], swe_v[0], soe_v[0], hb_v[0], lb_v[0], ack0_v[0], ack1_v[0]}), 32'h7C);
        check("rst_addr", 32'(saddr_v[0]), 32'h0);
        check("rst_rdata", {rdata0_v[0], rdata1_v[0]}, 32'h0);
        check("rst_ctl_ac15", 32'({cs_v[2], swe_v[2], soe_v[2], ack0_v[2], ack1_v[2]}), 32'h1C);

        // Both ports request together and keep requesting: 0,1,0,1 every 4 cycles
        we0_v[0] = 1'b1; addr0_v[0] = 18'h00020; wdata0_v[0] = 16'h1111; be0_v[0] = 2'b11;
        we1_v[0] = 1'b1; addr1_v[0] = 18'h00021; wdata1_v[0] = 16'h2222; be1_v[0] = 2'b11;
        req0_v[0] = 1'b1; req1_v[0] = 1'b1;
        n_ack = 0;
        for (int c = 1; c <= 16; c++) begin
            @(posedge clk); #1;
            if (ack0_v[0] && n_ack < 8) begin ack_c[n_ack] = c; ack_p[n_ack] = 0; n_ack++; end
            if (ack1_v[0] && n_ack < 8) begin ack_c[n_ack] = c; ack_p[n_ack] = 1; n_ack++; end
        end
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
        check("tie_count", 32'(n_ack), 32'd4);
        for (int k = 0; k < 4 && k < n_ack; k++) begin
            check($sformatf("tie%0d_cycle", k), 32'(ack_c[k]), 32'(3 + 4 * k));
            check($sformatf("tie%0d_port", k), 32'(ack_p[k]), 32'(k % 2));
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset in the second ACCESS cycle of a port-1 write
        we1_v[0] = 1'b1; addr1_v[0] = 18'h00030; wdata1_v[0] = 16'h5A5A; be1_v[0] = 2'b11; req1_v[0] = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("mid_we_low", 32'(swe_v[0]), 32'h0);
        check("mid_drive", 32'(bus_v[0] == 16'h5A5A), 32'h1);
        #2 rst_v[0] = 1'b1;
        #1;
        check("mid_rst_strobes", 32'({cs_v[0], swe_v[0], soe_v[0]}), 32'h7);
        check("mid_rst_bus", 32'(bus_v[0] == 16'h5A5A), 32'h0);
        a1 = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (ack1_v[0]) a1++;
        end
        check("mid_rst_noack", 32'(a1), 32'h0);
        @(negedge clk);
        rst_v[0] = 1'b0;
        we0_v[0] = 1'b1; addr0_v[0] = 18'h00031; wdata0_v[0] = 16'h6B6B; be0_v[0] = 2'b11; req0_v[0] = 1'b1;
        a0 = 0; a1 = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if (ack0_v[0] && a0 == 0) begin a0 = c; req0_v[0] = 1'b0; end
            if (ack1_v[0] && a1 == 0) begin a1 = c; req1_v[0] = 1'b0; end
        end
        req0_v[0] = 1'b0; req1_v[0] = 1'b0;
        check("post_rst_ack0", 32'(a0), 32'd3);
        check("post_rst_ack1", 32'(a1), 32'd7);

        for (int k = 0; k < 12; k++) begin
            run_vec(vecs[k], lat, we_lo, oe_lo, clash, hold);
            if (!vecs[k].we) exp_rd[vecs[k].inst][vecs[k].port] = vecs[k].rd;
            check($sformatf("vec%0d_lat", k), 32'(lat), 32'(vecs[k].lat));
            check($sformatf("vec%0d_strobes", k), {we_lo[15:0], oe_lo[15:0]},
                  vecs[k].we ? {16'(vecs[k].strobes), 16'h0} : {16'h0, 16'(vecs[k].strobes)});
            check($sformatf("vec%0d_clash", k), 32'(clash), 32'h0);
            check($sformatf("vec%0d_hold", k), 32'(hold), 32'(vecs[k].we));
            check($sformatf("vec%0d_rdata", k),
                  vecs[k].port ? 32'(rdata1_v[vecs[k].inst]) : 32'(rdata0_v[vecs[k].inst]),
                  32'(exp_rd[vecs[k].inst][vecs[k].port]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and access sequencer for the DE2 board's 256K×16 asynchronous SRAM. It grants one of two requesters (port 0, port 1) per access with round-robin priority. It drives the SRAM pins with controlled, counted timing: chip select, write enable, output enable, byte masks, address and a tri-state data bus. It sits between the client logic (pattern writer, readback/display path) and the SRAM pins, and replaces direct pin driving by those clients.

## Interface
- ACCESS_CYCLES, 2, Clock cycles the WE or OE strobe stays low per access; legal range 1..15.
- Clock  input  1  system clock, 50 MHz; all state changes on the rising edge.
- Reset  input  1  asynchronous, active-high; clears all state immediately.
- Req0 / Req1  input  1  access request; held high until the matching Ack.
- We0 / We1  input  1  1 = write, 0 = read; sampled at grant.
- Addr0 / Addr1  input  18  word address; sampled at grant.
- WData0 / WData1  input  16  write data; sampled at grant.
- Be0 / Be1  input  2  byte enables, [1] = high byte, [0] = low byte; sampled at grant.
- Ack0 / Ack1  output  1  one-cycle completion pulse.
- RData0 / RData1  output  16  read data; valid with Ack on a read; held until that port's next read completes.
- SRAM_Data  inout  16  SRAM data bus.
- SRAM_Address  output  18  SRAM address.
- SRAM_Write_Enable, SRAM_Output_Enable, CS, HbMask, LbMask  output  1 each  SRAM controls, all active-low.

## Operation
- FSM states:
  - IDLE: SRAM idle, looking for a request.
  - ACCESS: strobes active for ACCESS_CYCLES.
  - DONE: one cycle; strobes released, Ack pulsed.
- IDLE, no request: stay in IDLE.
- IDLE, one request: grant that port.
- IDLE, both requests: grant the port not granted last. The last-granted pointer resets to 1, so port 0 wins the first tie.
- Grant action: latch We, Addr, WData and Be of the granted port into the command register; load the counter with ACCESS_CYCLES−1; go to ACCESS.
- ACCESS:
  - CS=0.
  - HbMask=~Be[1], LbMask=~Be[0].
  - SRAM_Address = latched address.
  - Write: SRAM_Write_Enable=0, SRAM_Output_Enable=1, SRAM_Data driven with latched data.
  - Read: SRAM_Output_Enable=0, SRAM_Write_Enable=1, SRAM_Data released (Z).
  - Counter decrements each cycle; at 0, a read captures SRAM_Data into the granted port's RData register, then go to DONE.
- DONE:
  - WE=1, OE=1, CS=1, masks=1.
  - Address held.
  - Write data stays driven for this one cycle (hold time), then is released.
  - Ack of the granted port =1; update the last-granted pointer; go to IDLE.
- Requests from the non-granted port are ignored until IDLE.
- Deasserting Req after grant is a protocol violation. The access still completes and Ack still pulses.
- Be=00: the cycle runs with both masks high (no byte written or read), and Ack is still issued. RData is updated with the undriven-bus value; don't-care.
- SRAM_Data is never driven by this block while SRAM_Output_Enable=0.

## Timing
- Reset values: CS=1, SRAM_Write_Enable=1, SRAM_Output_Enable=1, HbMask=1, LbMask=1, SRAM_Address=0, SRAM_Data=Z, Ack0=Ack1=0, RData0=RData1=0, state=IDLE, pointer=1.
- Latency: Req seen high in IDLE at edge N → ACCESS during cycles N+1..N+ACCESS_CYCLES → Ack high during cycle N+ACCESS_CYCLES+1.
- Throughput: one access per ACCESS_CYCLES+2 cycles. The IDLE turnaround cycle is mandatory; back-to-back grants never skip it.
- Read data is sampled at the end of the last ACCESS cycle. At the default setting that is 40 ns after OE and address, well above the 10 ns tAA.
- Reset mid-access: strobes return high and the bus goes Z asynchronously; no Ack; the in-flight write result is undefined.
- All outputs are registered (no combinational paths from Req to pins), except the SRAM_Data tri-state enable, which is a registered flag.

## Structure
- Package sram_arb_pkg holds:
  - SRAM_AW=18 and SRAM_DW=16.
  - State enum {IDLE, ACCESS, DONE}.
  - Command struct {we, addr, wdata, be}.
- One sub-module, rr_arb2: two-request round-robin picker with pointer update on a done strobe. Everything else lives in sram_arbiter.
- The bench uses a behavioural async-SRAM model with 10 ns tAA and checks for bus contention.

## Test plan
- Reset, then Req0 write Addr0=18'h00005, WData0=16'hBEEF, Be0=11 → Ack0 at N+3 (ACCESS_CYCLES=2); model word 5 = BEEF; WE low for exactly 2 cycles.
- Req0 read of address 5 → RData0=16'hBEEF with Ack0; OE low for 2 cycles; SRAM_Data never driven by the DUT in that window.
- Req0 and Req1 high from the same cycle, continuous → grants alternate 0,1,0,1; each Ack separated by 4 cycles.
- Write Be=10, WData=16'h1234 to a word holding 16'hFFFF → read back 16'h12FF.
- Assert Reset during the second ACCESS cycle of a write → CS/WE high and bus Z in the same cycle; no Ack; after release the next request is granted normally to port 0.
- ACCESS_CYCLES=1 and 15 builds: the Ack-latency formula holds; address 18'h3FFFF round-trips 16'hA5A5.
